// File: rtl/my_div.sv
// my_div: fixed-latency signed fixed-point divider, radix-2 restoring with saturation
module my_div #(
  parameter int DATA_WIDTH = 64,
  parameter int INT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  ready,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  valid,
  output logic                  ovf,
  output logic                  dz
);
  localparam int DW = DATA_WIDTH;
  localparam int FRAC = DW - INT_WIDTH;
  localparam int N = DW + FRAC;
  localparam int CW = $clog2(N + 1);
  localparam logic [N-1:0] LIM = {{(N-1){1'b0}}, 1'b1} << (DW - 1);
  localparam logic [DW-1:0] MAXP = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] MINN = {1'b1, {(DW-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [DW:0] bm, abs_a, abs_b, sh;
  logic [DW+1:0] diff;
  logic [DW-1:0] r, mag, fq;
  logic [N-1:0] qd;
  logic sa, neg, bz, ge, of;
  // magnitudes, one restoring step, and the signed/saturated result
  always_comb begin
    abs_a = a[DW-1] ? -{a[DW-1], a} : {a[DW-1], a};
    abs_b = b[DW-1] ? -{b[DW-1], b} : {b[DW-1], b};
    sh = {r, qd[N-1]};
    diff = {1'b0, sh} - {1'b0, bm};
    ge = !diff[DW+1];
    of = neg ? (qd > LIM) : (qd >= LIM);
    mag = qd[DW-1:0];
    fq = bz ? (sa ? MINN : MAXP) : of ? (neg ? MINN : MAXP) : neg ? -mag : mag;
  end
  // control FSM and datapath; the extra CALC cycle at cnt==N pads latency to N+2
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ready <= 1'b1;
      valid <= 1'b0;
      q <= '0;
      ovf <= 1'b0;
      dz <= 1'b0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          sa <= a[DW-1];
          neg <= a[DW-1] ^ b[DW-1];
          bm <= abs_b;
          bz <= (b == '0);
          r <= '0;
          qd <= N'(abs_a) << FRAC;
          cnt <= '0;
          ready <= 1'b0;
          state <= CALC;
        end
        CALC: if (cnt == CW'(N)) state <= FIX;
        else begin
          cnt <= cnt + CW'(1);
          r <= ge ? diff[DW-1:0] : sh[DW-1:0];
          qd <= {qd[N-2:0], ge};
        end
        FIX: begin
          q <= fq;
          ovf <= !bz && of;
          dz <= bz;
          valid <= 1'b1;
          state <= DONE;
        end
        default: begin
          valid <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_my_div.sv
// tb_my_div: vector table, random model check and corner sequences for my_div
module tb_my_div;
  logic clk = 0, rst = 1, start = 0;
  logic [31:0] a = 0, b = 0;
  logic ready, valid, ovf, dz;
  logic [31:0] q;
  int vectors = 0, miscompares = 0;

  my_div #(.DATA_WIDTH(32), .INT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .ready(ready), .q(q), .valid(valid), .ovf(ovf), .dz(dz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a, b, q;
    logic ovf, dz;
  } vec_t;

  task chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic void model(input logic [31:0] ta, input logic [31:0] tb_,
                                output logic [31:0] eq, output logic eo, output logic ed);
    longint sa = longint'($signed(ta));
    longint sb = longint'($signed(tb_));
    longint r;
    ed = (sb == 0);
    eo = 0;
    if (ed) eq = (sa < 0) ? 32'h80000000 : 32'h7FFFFFFF;
    else begin
      r = (sa * 65536) / sb;
      if (r > 64'sd2147483647) begin eq = 32'h7FFFFFFF; eo = 1; end
      else if (r < -64'sd2147483648) begin eq = 32'h80000000; eo = 1; end
      else eq = r[31:0];
    end
  endfunction

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!ready && n < 200) begin @(negedge clk); n++; end
    if (!ready) chk("ready_timeout", {31'b0, ready}, 32'd1);
  endtask

  task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_,
                       output logic [31:0] rq, output logic ro, output logic rd, output int lat);
    wait_ready();
    a = ta; b = tb_; start = 1;
    @(posedge clk); #1 start = 0;
    lat = 0;
    while (!valid && lat < 200) begin @(posedge clk); #1; lat++; end
    rq = q; ro = ovf; rd = dz;
  endtask

  task automatic check_op(input string nm, input logic [31:0] ta, input logic [31:0] tb_);
    logic [31:0] rq, eq;
    logic ro, rd, eo, ed;
    int lat;
    model(ta, tb_, eq, eo, ed);
    do_op(ta, tb_, rq, ro, rd, lat);
    chk({nm, "_q"}, rq, eq);
    chk({nm, "_ovf"}, {31'b0, ro}, {31'b0, eo});
    chk({nm, "_dz"}, {31'b0, rd}, {31'b0, ed});
    chk({nm, "_lat"}, lat, 32'd50);
  endtask

  task automatic watch_no_valid(input string nm, input int cycles);
    int seen = 0;
    repeat (cycles) begin @(posedge clk); #1; if (valid) seen++; end
    chk(nm, seen, 0);
  endtask

  initial begin
    vec_t tbl[8];
    logic [31:0] rq, held, ta, tb_;
    logic ro, rd;
    int lat, busy_bad, held_bad;
    tbl[0] = '{32'h00030000, 32'h00020000, 32'h00018000, 1'b0, 1'b0};
    tbl[1] = '{32'hFFFF0000, 32'h00030000, 32'hFFFFAAAB, 1'b0, 1'b0};
    tbl[2] = '{32'h7FFF0000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b0};
    tbl[3] = '{32'h80000000, 32'h00010000, 32'h80000000, 1'b0, 1'b0};
    tbl[4] = '{32'h00050000, 32'h00000000, 32'h7FFFFFFF, 1'b0, 1'b1};
    tbl[5] = '{32'hFFFB0000, 32'h00000000, 32'h80000000, 1'b0, 1'b1};
    tbl[6] = '{32'h00000000, 32'hFFFD0000, 32'h00000000, 1'b0, 1'b0};
    tbl[7] = '{32'hFFFE8000, 32'hFFFF8000, 32'h00030000, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'b0, ready}, 32'd1);
    chk("rst_valid", {31'b0, valid}, 32'd0);
    chk("rst_q", q, 32'd0);
    chk("rst_ovf", {31'b0, ovf}, 32'd0);
    chk("rst_dz", {31'b0, dz}, 32'd0);
    rst = 0;

    for (int i = 0; i < 8; i++) begin
      do_op(tbl[i].a, tbl[i].b, rq, ro, rd, lat);
      chk($sformatf("tbl%0d_q", i), rq, tbl[i].q);
      chk($sformatf("tbl%0d_ovf", i), {31'b0, ro}, {31'b0, tbl[i].ovf});
      chk($sformatf("tbl%0d_dz", i), {31'b0, rd}, {31'b0, tbl[i].dz});
      chk($sformatf("tbl%0d_lat", i), lat, 32'd50);
    end

    for (int i = 0; i < 40; i++) begin
      ta = $urandom >> $urandom_range(0, 31);
      tb_ = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1)) ta = -ta;
      if ($urandom_range(0, 1)) tb_ = -tb_;
      if (i % 10 == 9) tb_ = 0;
      check_op($sformatf("rnd%0d", i), ta, tb_);
    end

    // start spam while busy: only the first operation counts, q holds old value
    wait_ready();
    held = q;
    a = 32'h00030000; b = 32'h00020000; start = 1;
    @(posedge clk);
    lat = 0; busy_bad = 0; held_bad = 0;
    #1;
    while (!valid && lat < 200) begin
      @(negedge clk);
      a = $urandom; b = $urandom;
      if (ready) busy_bad++;
      if (q !== held) held_bad++;
      @(posedge clk); #1; lat++;
    end
    start = 0;
    chk("spam_q", q, 32'h00018000);
    chk("spam_lat", lat, 32'd50);
    chk("spam_ready_low", busy_bad, 0);
    chk("spam_q_held", held_bad, 0);

    // start in the DONE cycle is ignored
    a = 32'h00010000; b = 32'h00010000; start = 1;
    @(posedge clk); #1 start = 0;
    chk("done_start_ignored", {31'b0, ready}, 32'd1);
    watch_no_valid("done_start_no_valid", 60);

    // back-to-back operations
    check_op("b2b0", 32'h00010000, 32'hFFFF0000);
    check_op("b2b1", 32'h00070000, 32'h00020000);

    // reset in the middle of CALC aborts
    wait_ready();
    a = 32'h00090000; b = 32'h00020000; start = 1;
    @(posedge clk); #1 start = 0;
    repeat (19) @(posedge clk);
    @(negedge clk) rst = 1;
    @(posedge clk); #1 rst = 0;
    chk("abort_ready", {31'b0, ready}, 32'd1);
    chk("abort_valid", {31'b0, valid}, 32'd0);
    chk("abort_q", q, 32'd0);
    chk("abort_ovf", {31'b0, ovf}, 32'd0);
    chk("abort_dz", {31'b0, dz}, 32'd0);
    watch_no_valid("abort_no_valid", 60);
    check_op("after_abort", 32'h00090000, 32'h00020000);

    // reset overrides a simultaneous start
    @(negedge clk);
    rst = 1; start = 1; a = 32'h00040000; b = 32'h00020000;
    @(posedge clk); #1 rst = 0; start = 0;
    chk("rst_start_ready", {31'b0, ready}, 32'd1);
    watch_no_valid("rst_start_no_valid", 60);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/my_div.md
MY_DIV -- requirements
Module: my_div

Interface
REQ-001 Parameter DATA_WIDTH, default 64: operand/result width, two's-complement fixed point (INT_WIDTH integer bits incl. sign, FRAC = DATA_WIDTH-INT_WIDTH fraction bits).
REQ-002 Parameter INT_WIDTH, default 16: integer bits; SHALL satisfy DATA_WIDTH >= INT_WIDTH >= 1.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request; sampled only when ready=1.
REQ-006 a  input  DATA_WIDTH  dividend, signed fixed point.
REQ-007 b  input  DATA_WIDTH  divisor, signed fixed point.
REQ-008 ready  output  1  high in IDLE only.
REQ-009 q  output  DATA_WIDTH  quotient a/b, same Q format as operands.
REQ-010 valid  output  1  one-cycle pulse, q/ovf/dz valid.
REQ-011 ovf  output  1  result saturated (magnitude out of range).
REQ-012 dz  output  1  divisor was zero.

Function
REQ-013 States SHALL be IDLE, CALC, FIX, DONE; encoding free.
REQ-014 IDLE: ready=1; start=1 registers a, b, result sign (a[MSB] xor b[MSB]), |a| and |b| in DATA_WIDTH+1 bits, iteration counter=0; next CALC.
REQ-015 Inputs a, b SHALL be ignored outside the IDLE start edge; changes during CALC have no effect.
REQ-016 CALC: radix-2 restoring division of |a|<<FRAC by |b|, one quotient bit per cycle, N = DATA_WIDTH+FRAC cycles; after N cycles next FIX.
REQ-017 Quotient magnitude SHALL truncate toward zero (remainder discarded, no rounding).
REQ-018 FIX: apply sign; if positive result > 2^(DATA_WIDTH-1)-1 -> q=max positive, ovf=1; if negative result magnitude > 2^(DATA_WIDTH-1) -> q=min negative (1 followed by zeros), ovf=1; exact min negative SHALL NOT flag ovf; next DONE.
REQ-019 b=0: q=max positive if a>=0, min negative if a<0; dz=1, ovf=0; latency unchanged (fixed latency for all operands).
REQ-020 DONE: valid=1 for exactly one cycle; next IDLE (ready=1 the following cycle).
REQ-021 Latency: valid SHALL be high in the cycle after the N+2-th rising edge following the edge that sampled start.
REQ-022 q, ovf, dz SHALL hold their values from DONE until the next DONE (registered, stable while busy).
REQ-023 start while ready=0 SHALL be ignored (no queueing); start in DONE cycle ignored.
REQ-024 Zero dividend SHALL give q=0, ovf=0 (no negative zero artefact).

Reset
REQ-025 rst=1 at a rising edge: state IDLE, ready=1, valid=0, q=0, ovf=0, dz=0, counter=0.
REQ-026 rst during CALC/FIX/DONE SHALL abort: no valid pulse for the aborted operation; rst overrides simultaneous start.

Verification (DATA_WIDTH=32, INT_WIDTH=16, N=48)
REQ-027 a=0x00030000, b=0x00020000, start -> valid exactly 50 edges after sampling edge, q=0x00018000, ovf=0, dz=0.
REQ-028 a=0xFFFF0000, b=0x00030000 -> q=0xFFFFAAAB (trunc toward zero), ovf=0.
REQ-029 a=0x7FFF0000, b=0x00000001 -> q=0x7FFFFFFF, ovf=1; a=0x80000000, b=0x00010000 -> q=0x80000000, ovf=0.
REQ-030 a=0x00050000, b=0 -> q=0x7FFFFFFF, dz=1; a=0xFFFB0000, b=0 -> q=0x80000000, dz=1; both same 50-cycle latency.
REQ-031 start pulses each cycle during CALC with different operands -> only first result produced; ready low throughout; back-to-back ops: start in first ready cycle after DONE accepted.
REQ-032 rst asserted at CALC cycle 20 -> no valid, outputs zero, ready=1 next cycle; new op afterwards gives correct result.
